// File: rtl/tdm_mux_pkg.sv
//==============================================================================
// Module      : tdm_mux_pkg
// Description : Shared constants and helpers for the tdm_mux_scan block.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package tdm_mux_pkg;

    // Encoding of the mode input
    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Select width for n channels; never narrower than one bit
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/tdm_mux_scan_mux_n_sel.sv
//==============================================================================
// Module      : mux_n_sel
// Description : Combinational CHANNELS:1 selector of WIDTH-bit words plus the
//               matching per-channel valid bit. Out-of-range selects return
//               zero data, zero valid and raise out_of_range.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mux_n_sel
    import tdm_mux_pkg::*;
#(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 16,
    localparam int SEL_W    = sel_width(CHANNELS)
) (
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    output logic                      out_of_range
);

    // One-hot compare against every legal index; no match means out of range
    always_comb begin
        out_data     = '0;
        out_valid    = 1'b0;
        out_of_range = 1'b1;
        for (int c = 0; c < CHANNELS; c++) begin
            if (sel == SEL_W'(c)) begin
                out_data     = in_data[c*WIDTH +: WIDTH];
                out_valid    = in_valid[c];
                out_of_range = 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/tdm_mux_scan.sv
//==============================================================================
// Module      : tdm_mux_scan
// Description : N:1 time-division multiplexer with manual select, round-robin
//               scan with programmable dwell, optional idle-channel skipping
//               and a registered valid/ready output stage.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tdm_mux_scan
    import tdm_mux_pkg::*;
#(
    parameter  int WIDTH        = 8,
    parameter  int CHANNELS     = 16,
    parameter  int DWELL_W      = 8,
    parameter  bit SKIP_INVALID = 1'b0,
    localparam int SEL_W        = sel_width(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [DWELL_W-1:0]        dwell,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      scan_wrap
);

    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               wrap_pend_q, wrap_pend_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic [SEL_W-1:0]   out_chan_q, out_chan_d;
    logic               scan_wrap_q, scan_wrap_d;

    logic [SEL_W-1:0]   w_ptr_eff;
    logic               w_load;
    logic [WIDTH-1:0]   w_mux_data;
    logic               w_mux_valid;
    logic               w_mux_oor;

    // Channel addressed this cycle: the manual select or the scan pointer
    assign w_ptr_eff = (mode == MODE_MANUAL) ? sel : ptr_q;
    assign w_load    = !out_valid_q || out_ready;

    mux_n_sel #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS)
    ) u_mux (
        .in_data      (in_data),
        .in_valid     (in_valid),
        .sel          (w_ptr_eff),
        .out_data     (w_mux_data),
        .out_valid    (w_mux_valid),
        .out_of_range (w_mux_oor)
    );

    // Capture, pointer/dwell sequencing and wrap flagging; everything holds on a stall.
    // wrap_pend remembers a pointer wrap so scan_wrap lines up with the channel-0 sample.
    always_comb begin
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        wrap_pend_d = wrap_pend_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_chan_d  = out_chan_q;
        scan_wrap_d = 1'b0;

        if (w_load) begin
            out_data_d  = w_mux_data;
            out_valid_d = w_mux_valid;
            out_chan_d  = w_ptr_eff;
            scan_wrap_d = wrap_pend_q && (mode == MODE_SCAN);
            wrap_pend_d = 1'b0;

            if (mode == MODE_MANUAL) begin
                if (!w_mux_oor) begin
                    ptr_d = sel;
                end
                cnt_d = '0;
            end else if ((SKIP_INVALID && !w_mux_valid) || (cnt_q >= dwell)) begin
                // Advance; >= lets a lowered dwell take effect on the next load
                cnt_d = '0;
                if (ptr_q == SEL_W'(CHANNELS - 1)) begin
                    ptr_d       = '0;
                    wrap_pend_d = 1'b1;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= '0;
            cnt_q       <= '0;
            wrap_pend_q <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_chan_q  <= '0;
            scan_wrap_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            wrap_pend_q <= wrap_pend_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_chan_q  <= out_chan_d;
            scan_wrap_q <= scan_wrap_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_chan  = out_chan_q;
    assign scan_wrap = scan_wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_tdm_mux_scan.sv
//==============================================================================
// Module      : tb_tdm_mux_scan
// Description : Self-checking bench for tdm_mux_scan. Two instances: 16
//               channels without skipping, and 5 channels with skipping.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_tdm_mux_scan;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] in_data_a;
    logic [15:0]  in_valid_a;
    logic         mode;
    logic [3:0]   sel_a;
    logic [2:0]   sel_b;
    logic [7:0]   dwell;
    logic         ready;

    logic [7:0]   od_a, od_b;
    logic         ov_a, ov_b;
    logic [3:0]   oc_a;
    logic [2:0]   oc_b;
    logic         wr_a, wr_b;

    int tests  = 0;
    int failed = 0;

    tdm_mux_scan #(
        .WIDTH(8), .CHANNELS(16), .DWELL_W(8), .SKIP_INVALID(1'b0)
    ) u_dut_a (
        .clk(clk), .rst(rst), .in_data(in_data_a), .in_valid(in_valid_a),
        .mode(mode), .sel(sel_a), .dwell(dwell), .out_data(od_a),
        .out_valid(ov_a), .out_ready(ready), .out_chan(oc_a), .scan_wrap(wr_a)
    );

    tdm_mux_scan #(
        .WIDTH(8), .CHANNELS(5), .DWELL_W(8), .SKIP_INVALID(1'b1)
    ) u_dut_b (
        .clk(clk), .rst(rst), .in_data(in_data_a[39:0]), .in_valid(in_valid_a[4:0]),
        .mode(mode), .sel(sel_b), .dwell(dwell), .out_data(od_b),
        .out_valid(ov_b), .out_ready(ready), .out_chan(oc_b), .scan_wrap(wr_b)
    );

    initial forever #5 clk = ~clk;

    // Reference model: observable output register plus scan pointer and dwell count
    typedef struct {
        int ptr;
        int cnt;
        int od;
        bit ov;
        int oc;
        bit wrap;
    } mstate_t;

    mstate_t ma, mb, mreset;

    function automatic mstate_t mstep(mstate_t s, int nch, bit skip, logic [127:0] d,
                                      logic [15:0] v, bit md, int sl, int dw, bit rdy);
        mstate_t n;
        int      e;
        bit      inr;
        n      = s;
        n.wrap = 1'b0;
        if (s.ov && !rdy) return n;
        e      = md ? s.ptr : sl;
        inr    = (e < nch);
        n.od   = inr ? int'(d[e*8 +: 8]) : 0;
        n.ov   = inr && v[e];
        n.oc   = e;
        // Wrap is seen when a scan capture of channel 0 follows a capture of the last channel
        n.wrap = md && (e == 0) && (s.oc == nch - 1);
        if (!md) begin
            if (inr) n.ptr = sl;
            n.cnt = 0;
        end else if ((skip && !v[e]) || (s.cnt >= dw)) begin
            n.ptr = (s.ptr + 1) % nch;
            n.cnt = 0;
        end else begin
            n.cnt = s.cnt + 1;
        end
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("a_data",  32'(od_a), 32'(ma.od));
        check("a_valid", 32'(ov_a), 32'(ma.ov));
        check("a_chan",  32'(oc_a), 32'(ma.oc));
        check("a_wrap",  32'(wr_a), 32'(ma.wrap));
        check("b_data",  32'(od_b), 32'(mb.od));
        check("b_valid", 32'(ov_b), 32'(mb.ov));
        check("b_chan",  32'(oc_b), 32'(mb.oc));
        check("b_wrap",  32'(wr_b), 32'(mb.wrap));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            ma = mreset;
            mb = mreset;
        end else begin
            ma = mstep(ma, 16, 1'b0, in_data_a, in_valid_a, mode, int'(sel_a), int'(dwell), ready);
            mb = mstep(mb, 5,  1'b1, in_data_a, in_valid_a, mode, int'(sel_b), int'(dwell), ready);
        end
        #1;
        compare_all();
    endtask

    initial begin
        int na;
        int nb;
        mreset     = '{ptr: 0, cnt: 0, od: 0, ov: 1'b0, oc: 0, wrap: 1'b0};
        ma         = mreset;
        mb         = mreset;
        rst        = 1'b1;
        mode       = 1'b0;
        sel_a      = '0;
        sel_b      = '0;
        dwell      = '0;
        ready      = 1'b1;
        in_data_a  = '0;
        in_valid_a = '0;

        // Reset state
        repeat (2) tick();
        check("rst_a_valid", 32'(ov_a), 32'd0);
        check("rst_b_chan",  32'(oc_b), 32'd0);
        rst = 1'b0;

        // Manual select, plus an out-of-range select on the 5-channel instance
        sel_a                 = 4'd5;
        sel_b                 = 3'd6;
        in_data_a[5*8 +: 8]   = 8'hA5;
        in_valid_a[5]         = 1'b1;
        tick();
        check("man_a_data",  32'(od_a), 32'hA5);
        check("man_a_chan",  32'(oc_a), 32'd5);
        check("man_a_valid", 32'(ov_a), 32'd1);
        check("man_b_data",  32'(od_b), 32'd0);
        check("man_b_valid", 32'(ov_b), 32'd0);
        check("man_b_chan",  32'(oc_b), 32'd6);

        // Scan with dwell 2 from a fresh reset, channel c carries value c
        rst = 1'b1;
        tick();
        mode       = 1'b1;
        dwell      = 8'd2;
        in_valid_a = 16'hFFFF;
        for (int c = 0; c < 16; c++) in_data_a[c*8 +: 8] = 8'(c);
        rst = 1'b0;
        na  = 0;
        nb  = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            check("dwell_seq_a", 32'(oc_a), 32'((k / 3) % 16));
            if (wr_a) na++;
            if (wr_b) nb++;
        end
        check("wrap_count_a", 32'(na), 32'd2);
        check("wrap_count_b", 32'(nb), 32'd6);

        // Back-pressure: hold ready low for 5 cycles, then release
        ready = 1'b0;
        repeat (5) tick();
        ready = 1'b1;
        repeat (6) tick();

        // Idle-channel skipping with dwell 0
        dwell      = 8'd0;
        in_valid_a = 16'h0011;
        repeat (30) tick();

        // Randomized operation including stalls, mode flips and dwell changes
        for (int k = 0; k < 400; k++) begin
            in_data_a  = {$urandom, $urandom, $urandom, $urandom};
            in_valid_a = 16'($urandom);
            ready      = ($urandom_range(0, 3) != 0);
            sel_a      = 4'($urandom);
            sel_b      = 3'($urandom);
            if ($urandom_range(0, 30) == 0) mode = ~mode;
            if ($urandom_range(0, 20) == 0) dwell = 8'($urandom_range(0, 4));
            tick();
        end

        // Asynchronous reset in the middle of a stall
        mode       = 1'b1;
        in_valid_a = 16'hFFFF;
        ready      = 1'b1;
        repeat (3) tick();
        ready = 1'b0;
        repeat (2) tick();
        #3;
        rst = 1'b1;
        #1;
        check("arst_a_data",  32'(od_a), 32'd0);
        check("arst_a_valid", 32'(ov_a), 32'd0);
        check("arst_a_chan",  32'(oc_a), 32'd0);
        check("arst_b_data",  32'(od_b), 32'd0);
        check("arst_b_valid", 32'(ov_b), 32'd0);
        check("arst_b_chan",  32'(oc_b), 32'd0);
        ma = mreset;
        mb = mreset;
        tick();
        rst   = 1'b0;
        ready = 1'b1;
        tick();
        check("restart_a_chan", 32'(oc_a), 32'd0);
        check("restart_b_chan", 32'(oc_b), 32'd0);
        repeat (10) tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire
